// File: rtl/writeback_unit.sv
// Write-back stage controller: retires instructions from the memory stage
// and drives the register-file write port. Loads wait for the memory response.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_wr_en,
    input  logic              in_is_load,
    input  logic [DATA_W-1:0] in_alu,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] Caddr,
    output logic [DATA_W-1:0] C,
    output logic              load,
    output logic              busy,
    output logic [15:0]       retired,
    output logic              mem_err
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pend_dest;
    logic                r_pend_en;
    logic [ADDR_W-1:0]   r_caddr;
    logic [DATA_W-1:0]   r_c;
    logic                r_load;
    logic [15:0]         r_retired;
    logic                r_mem_err;
    logic                w_accept;
    logic                w_en;

    // Register 0 is hardwired: a write to it is dropped but still retires.
    assign w_en     = in_wr_en && (in_dest != '0);
    assign in_ready = (r_state == IDLE) && !clr;
    assign w_accept = in_valid && in_ready;

    assign Caddr    = r_caddr;
    assign C        = r_c;
    assign load     = r_load;
    assign busy     = (r_state == WAIT_MEM);
    assign retired  = r_retired;
    assign mem_err  = r_mem_err;

    // State register; clr drops any pending load.
    always_ff @(posedge clk) begin
        if (clr) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: park on an accepted load until its response arrives.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && in_is_load) w_next = WAIT_MEM;
            WAIT_MEM: if (mem_rvalid)             w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Write port, pending-load latch, retire counter and sticky error flag.
    // C/Caddr only move on a real write so they hold while load is low.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pend_dest <= '0;
            r_pend_en   <= 1'b0;
            r_caddr     <= '0;
            r_c         <= '0;
            r_load      <= 1'b0;
            r_retired   <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_load <= 1'b0;
            if (r_state == IDLE) begin
                // A response with nothing outstanding (even alongside a load
                // accept) belongs to no instruction.
                if (mem_rvalid) r_mem_err <= 1'b1;
                if (w_accept) begin
                    if (in_is_load) begin
                        r_pend_dest <= in_dest;
                        r_pend_en   <= w_en;
                    end else begin
                        r_retired <= r_retired + 16'd1;
                        r_load    <= w_en;
                        if (w_en) begin
                            r_caddr <= in_dest;
                            r_c     <= in_alu;
                        end
                    end
                end
            end else if (mem_rvalid) begin
                r_retired <= r_retired + 16'd1;
                r_load    <= r_pend_en;
                if (r_pend_en) begin
                    r_caddr <= r_pend_dest;
                    r_c     <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, retire-counter wrap,
// then random traffic against a transaction-level reference model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        clr, in_valid, in_wr_en, in_is_load, mem_rvalid;
    logic [3:0]  in_dest;
    logic [15:0] in_alu, mem_rdata;
    logic        in_ready, load, busy, mem_err;
    logic [3:0]  Caddr;
    logic [15:0] C, retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_unit #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_wr_en(in_wr_en), .in_is_load(in_is_load),
        .in_alu(in_alu), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .Caddr(Caddr), .C(C), .load(load), .busy(busy),
        .retired(retired), .mem_err(mem_err)
    );

    typedef struct {
        logic        clr, v;
        logic [3:0]  dest;
        logic        wen, ld;
        logic [15:0] alu;
        logic        rv;
        logic [15:0] rd;
        logic        e_load;
        logic [3:0]  e_caddr;
        logic [15:0] e_c;
        logic        e_busy, e_ready;
        logic [15:0] e_ret;
        logic        e_err;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic v, input logic [3:0] d, input logic w,
                         input logic l, input logic [15:0] a, input logic r, input logic [15:0] rd);
        clr = c; in_valid = v; in_dest = d; in_wr_en = w; in_is_load = l;
        in_alu = a; mem_rvalid = r; mem_rdata = rd;
    endtask

    // Reference model state: pending load queue (0 or 1 entries), outputs.
    typedef struct { logic [3:0] dest; logic en; } pend_t;
    pend_t       m_pend[$];
    logic        m_load, m_err;
    logic [3:0]  m_caddr;
    logic [15:0] m_c;
    int          m_ret;

    task automatic model_reset();
        m_pend.delete();
        m_load = 0; m_err = 0; m_caddr = 0; m_c = 0; m_ret = 0;
    endtask

    task automatic model_step();
        pend_t p;
        logic en;
        if (clr) begin
            model_reset();
            return;
        end
        m_load = 0;
        en = in_wr_en && (in_dest != 4'd0);
        if (m_pend.size() == 0) begin
            if (mem_rvalid) m_err = 1;
            if (in_valid) begin
                if (in_is_load) begin
                    p.dest = in_dest; p.en = en;
                    m_pend.push_back(p);
                end else begin
                    m_ret = (m_ret + 1) % 65536;
                    if (en) begin m_load = 1; m_caddr = in_dest; m_c = in_alu; end
                end
            end
        end else if (mem_rvalid) begin
            p = m_pend.pop_front();
            m_ret = (m_ret + 1) % 65536;
            if (p.en) begin m_load = 1; m_caddr = p.dest; m_c = mem_rdata; end
        end
    endtask

    initial begin
        //          clr v  dst wen ld alu      rv rd         load ca  c        busy rdy ret    err
        tbl[0]  = '{1, 0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0,    0, 0, 16'd0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0,    0, 0, 16'd0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0,    0, 1, 16'd0, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 16'h1111, 0, 16'h0,    1, 1, 16'h1111, 0, 1, 16'd1, 0};
        tbl[4]  = '{0, 1, 2, 1, 0, 16'h2222, 0, 16'h0,    1, 2, 16'h2222, 0, 1, 16'd2, 0};
        tbl[5]  = '{0, 1, 3, 1, 0, 16'h3333, 0, 16'h0,    1, 3, 16'h3333, 0, 1, 16'd3, 0};
        tbl[6]  = '{0, 1, 5, 1, 1, 16'h0,    0, 16'h0,    0, 3, 16'h3333, 1, 0, 16'd3, 0};
        tbl[7]  = '{0, 1, 7, 1, 0, 16'h7777, 0, 16'h0,    0, 3, 16'h3333, 1, 0, 16'd3, 0};
        tbl[8]  = '{0, 1, 7, 1, 0, 16'h7777, 0, 16'h0,    0, 3, 16'h3333, 1, 0, 16'd3, 0};
        tbl[9]  = '{0, 1, 7, 1, 0, 16'h7777, 0, 16'h0,    0, 3, 16'h3333, 1, 0, 16'd3, 0};
        tbl[10] = '{0, 1, 7, 1, 0, 16'h7777, 1, 16'hBEEF, 1, 5, 16'hBEEF, 0, 1, 16'd4, 0};
        tbl[11] = '{0, 1, 7, 1, 0, 16'h7777, 0, 16'h0,    1, 7, 16'h7777, 0, 1, 16'd5, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 16'hAAAA, 0, 16'h0,    0, 7, 16'h7777, 0, 1, 16'd6, 0};
        tbl[13] = '{0, 1, 4, 0, 0, 16'hBBBB, 0, 16'h0,    0, 7, 16'h7777, 0, 1, 16'd7, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 16'h0,    1, 16'hDEAD, 0, 7, 16'h7777, 0, 1, 16'd7, 1};
        tbl[15] = '{0, 1, 6, 1, 1, 16'h0,    0, 16'h0,    0, 7, 16'h7777, 1, 0, 16'd7, 1};
        tbl[16] = '{1, 0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0,    0, 0, 16'd0, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 16'h0,    1, 16'h1234, 0, 0, 16'h0,    0, 1, 16'd0, 1};
        tbl[18] = '{1, 0, 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0,    0, 0, 16'd0, 0};
        tbl[19] = '{0, 1, 9, 1, 1, 16'h0,    1, 16'h5555, 0, 0, 16'h0,    1, 0, 16'd0, 1};
        tbl[20] = '{0, 0, 0, 0, 0, 16'h0,    1, 16'h6666, 1, 9, 16'h6666, 0, 1, 16'd1, 1};
        tbl[21] = '{0, 1, 8, 0, 1, 16'h0,    0, 16'h0,    0, 9, 16'h6666, 1, 0, 16'd1, 1};
        tbl[22] = '{0, 0, 0, 0, 0, 16'h0,    1, 16'h7777, 0, 9, 16'h6666, 0, 1, 16'd2, 1};

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].clr, tbl[i].v, tbl[i].dest, tbl[i].wen, tbl[i].ld,
                  tbl[i].alu, tbl[i].rv, tbl[i].rd);
            @(posedge clk); #1;
            check($sformatf("row%0d load", i),    {31'd0, load},     {31'd0, tbl[i].e_load});
            check($sformatf("row%0d Caddr", i),   {28'd0, Caddr},    {28'd0, tbl[i].e_caddr});
            check($sformatf("row%0d C", i),       {16'd0, C},        {16'd0, tbl[i].e_c});
            check($sformatf("row%0d busy", i),    {31'd0, busy},     {31'd0, tbl[i].e_busy});
            check($sformatf("row%0d in_ready", i),{31'd0, in_ready}, {31'd0, tbl[i].e_ready});
            check($sformatf("row%0d retired", i), {16'd0, retired},  {16'd0, tbl[i].e_ret});
            check($sformatf("row%0d mem_err", i), {31'd0, mem_err},  {31'd0, tbl[i].e_err});
        end

        // Retire counter wrap: 65535 suppressed ALU retires, then one more.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, 0, 1, 0, 16'h1, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap ffff", {16'd0, retired}, 32'h0000FFFF);
        check("wrap noload", {31'd0, load}, 32'd0);
        @(posedge clk); #1;
        check("wrap zero", {16'd0, retired}, 32'd0);

        // Random traffic against the reference model.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(99) < 2), ($urandom_range(1) == 1), 4'($urandom_range(15)),
                  ($urandom_range(9) < 8), ($urandom_range(9) < 3), 16'($urandom),
                  ($urandom_range(9) < 2), 16'($urandom));
            #3;
            check("rnd in_ready", {31'd0, in_ready}, {31'd0, (!clr && m_pend.size() == 0)});
            @(posedge clk);
            model_step();
            #1;
            check("rnd load",    {31'd0, load},    {31'd0, m_load});
            check("rnd Caddr",   {28'd0, Caddr},   {28'd0, m_caddr});
            check("rnd C",       {16'd0, C},       {16'd0, m_c});
            check("rnd busy",    {31'd0, busy},    {31'd0, (m_pend.size() != 0)});
            check("rnd retired", {16'd0, retired}, m_ret);
            check("rnd mem_err", {31'd0, mem_err}, {31'd0, m_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage controller for the pipelined datapath. Accepts retiring instructions from the memory stage and drives the write port of the register file (`Caddr`, `C`, `load`). It holds load instructions until the data-memory response arrives. Register-file writes are registered, one per cycle at most, with a per-instruction retire count for bring-up.

## Interface
- `DATA_W`, 16, data width of register-file write data and memory read data
- `ADDR_W`, 4, register address width (16 registers)

Ports:
- `clk`  in  1  rising-edge clock; the only clock
- `clr`  in  1  synchronous, active-high reset
- `in_valid`  in  1  memory stage presents an instruction
- `in_ready`  out  1  unit accepts the instruction this cycle
- `in_dest`  in  ADDR_W  destination register
- `in_wr_en`  in  1  instruction writes a register
- `in_is_load`  in  1  write data comes from memory, not `in_alu`
- `in_alu`  in  DATA_W  ALU result
- `mem_rvalid`  in  1  data-memory read response valid (single-cycle pulse)
- `mem_rdata`  in  DATA_W  data-memory read data
- `Caddr`  out  ADDR_W  register-file write address
- `C`  out  DATA_W  register-file write data
- `load`  out  1  register-file write strobe, high for exactly one cycle per write
- `busy`  out  1  waiting for a memory response
- `retired`  out  16  count of completed instructions
- `mem_err`  out  1  sticky: `mem_rvalid` arrived while not waiting

## Operation
- States:
  - IDLE
  - WAIT_MEM
- `in_ready` = (state == IDLE) and not `clr`. An instruction is accepted when `in_valid` and `in_ready` are both high.
- IDLE, accept with `in_is_load` = 0:
  - Next cycle: `Caddr` = `in_dest`, `C` = `in_alu`.
  - `load` = `in_wr_en` and (`in_dest` != 0). Register 0 is never written.
  - `retired` increments; stay in IDLE.
- IDLE, accept with `in_is_load` = 1:
  - Latch `in_dest` and the effective write enable (same rule as above).
  - Go to WAIT_MEM.
- WAIT_MEM:
  - `busy` = 1 and `in_ready` = 0.
  - On `mem_rvalid`: next cycle `C` = `mem_rdata`, `Caddr` = latched dest, `load` = latched enable, `retired` increments, state returns to IDLE.
  - Without `mem_rvalid`: wait indefinitely; no timeout.
- Instructions with `in_wr_en` = 0 or destination 0 still retire and still follow the load/WAIT_MEM path if `in_is_load` = 1, but `load` stays 0.
- `mem_rvalid` in IDLE:
  - Data is ignored, no write occurs.
  - `mem_err` sets and stays set until `clr`.
- `retired` wraps from 0xFFFF to 0x0000.
- `C` and `Caddr` hold their last values when `load` = 0.

## Timing
- Reset values: state IDLE, `load` 0, `Caddr` 0, `C` 0, `busy` 0, `retired` 0, `mem_err` 0. `in_ready` is 0 while `clr` is high and 1 in the first cycle after.
- ALU path:
  - Accept at edge T; `load` is high during cycle T+1 (latency 1).
  - Back-to-back accepts give a write every cycle.
- Load path:
  - Accept at edge T; `mem_rvalid` sampled at edge T+k (k ≥ 1); `load` is high during cycle T+k+1.
  - `in_ready` returns to 1 in that same cycle, so the next instruction is accepted at edge T+k+1 at the earliest.
- `mem_rvalid` in the same cycle as a load is accepted belongs to no instruction: `mem_err` sets and the unit still enters WAIT_MEM.
- `clr` mid-WAIT_MEM: the pending load is dropped with no write. The state machine, all outputs and the counter take their reset values at that edge. A later `mem_rvalid` sets `mem_err`.
- `clr` has priority over every other input in the same cycle.

## Test plan
- Reset: assert `clr` 2 cycles, then release → `load` = 0, `retired` = 0, `mem_err` = 0, `in_ready` = 1 in the first cycle after release.
- ALU burst: 3 back-to-back accepts to dest 1, 2, 3 with `in_alu` 0x1111, 0x2222, 0x3333 → `load` high for 3 consecutive cycles with matching `Caddr`/`C`; `retired` = 3.
- Load: dest 5 load, `mem_rvalid` 4 cycles later with 0xBEEF → `busy` high and `in_ready` low for 4 cycles, then `load` = 1, `Caddr` = 5, `C` = 0xBEEF. An ALU instruction held on `in_valid` is accepted in the same cycle as that write.
- Suppression: ALU instruction to dest 0, and ALU instruction with `in_wr_en` = 0 → `load` stays 0; `retired` increments by 2.
- Error and reset: `mem_rvalid` in IDLE → `mem_err` = 1 and no write. `clr` during WAIT_MEM, then `mem_rvalid` → no write, `retired` = 0, `mem_err` = 1.
- Wrap: preload `retired` to 0xFFFF via 65535 retires, then one more → `retired` = 0x0000.
